fir_sample_scheduler: RTL and testbench

Sequences one ADC→FIR→DAC sample transaction per sample period on the 100 MHz system clock.
- Generates the sample tick and ADC capture strobe, and presents each sample to the band-pass FIR with a valid strobe.
- Waits for the filtered result, then scales and saturates it to 8 bits and hands it to the serial DAC driver with a req/ack handshake.
- Counts overruns and FIR timeouts for debug.
- Sits between the ADC driver, the FIR, and the DAC driver in the top level.

---
 rtl/fir_sched_pkg.sv | 14 +
 rtl/sat_scale.sv | 16 +
 rtl/fir_sample_scheduler.sv | 97 +++++++++
 tb/tb_fir_sample_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared state encoding, DAC width and saturating counter helper for the sample scheduler.
package fir_sched_pkg;
  localparam int DAC_W = 8;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    LOAD     = 3'd2,
    FIR_WAIT = 3'd3,
    DAC_REQ  = 3'd4
  } state_t;
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/sat_scale.sv
// sat_scale: arithmetic shift of a signed accumulator, saturate to 8 bits signed, convert to offset binary.
module sat_scale
  import fir_sched_pkg::*;
#(
  parameter int ACC_W = 21,
  parameter int SHIFT = 10
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic [DAC_W-1:0]        o_dac
);
  localparam logic signed [ACC_W-1:0] MAX_V = 127;
  localparam logic signed [ACC_W-1:0] MIN_V = -128;
  logic signed [ACC_W-1:0] w_s;
  assign w_s = i_acc >>> SHIFT;
  always_comb o_dac = (w_s > MAX_V) ? 8'hFF : (w_s < MIN_V) ? 8'h00 : {~w_s[7], w_s[6:0]};
endmodule

// File: rtl/fir_sample_scheduler.sv
// fir_sample_scheduler: sequences one ADC->FIR->DAC sample transaction per sample period.
// Define FIR_BYPASS_EN to add a bypass input that routes the ADC sample straight to the DAC.
module fir_sample_scheduler
  import fir_sched_pkg::*;
#(
  parameter int SAMPLE_DIV  = 100,
  parameter int ACC_W       = 21,
  parameter int SHIFT       = 10,
  parameter int FIR_TIMEOUT = 64
) (
  input  logic                    clk_100MHz,
  input  logic                    rst_n,
  input  logic                    enable,
`ifdef FIR_BYPASS_EN
  input  logic                    bypass,
`endif
  input  logic [7:0]              adc_data,
  output logic                    adc_en,
  output logic [7:0]              fir_in_data,
  output logic                    fir_in_valid,
  input  logic signed [ACC_W-1:0] fir_out_data,
  input  logic                    fir_out_valid,
  output logic [DAC_W-1:0]        dac_data,
  output logic                    dac_req,
  input  logic                    dac_ack,
  output logic                    busy,
  output logic [15:0]             overrun_cnt,
  output logic [15:0]             timeout_cnt
);
  state_t           r_state;
  logic [15:0]      r_cnt;
  logic [15:0]      r_wait;
  logic [7:0]       r_fir_in_data;
  logic [DAC_W-1:0] r_dac_data;
  logic [15:0]      r_overrun;
  logic [15:0]      r_timeout;
  logic             w_tick;
  logic             w_bypass;
  logic [DAC_W-1:0] w_scaled;
`ifdef FIR_BYPASS_EN
  assign w_bypass = bypass;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_tick       = enable && (r_cnt == 16'(SAMPLE_DIV - 1));
  assign adc_en       = r_state == CAPTURE;
  assign fir_in_valid = (r_state == LOAD) && !w_bypass;
  assign dac_req      = r_state == DAC_REQ;
  assign busy         = r_state != IDLE;
  assign fir_in_data  = r_fir_in_data;
  assign dac_data     = r_dac_data;
  assign overrun_cnt  = r_overrun;
  assign timeout_cnt  = r_timeout;
  sat_scale #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_sat_scale (
    .i_acc(fir_out_data),
    .o_dac(w_scaled)
  );
  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_wait        <= '0;
      r_fir_in_data <= '0;
      r_dac_data    <= '0;
      r_overrun     <= '0;
      r_timeout     <= '0;
    end else begin
      r_cnt <= (!enable || w_tick) ? '0 : r_cnt + 16'd1;
      // a tick outside IDLE is dropped, never queued
      if (w_tick && r_state != IDLE) r_overrun <= sat_inc16(r_overrun);
      case (r_state)
        IDLE: if (w_tick) r_state <= CAPTURE;
        CAPTURE: begin
          r_fir_in_data <= {~adc_data[7], adc_data[6:0]};
          r_state       <= LOAD;
        end
        LOAD: begin
          r_wait <= '0;
          if (w_bypass) begin
            r_dac_data <= adc_data;
            r_state    <= DAC_REQ;
          end else r_state <= FIR_WAIT;
        end
        FIR_WAIT:
          if (fir_out_valid) begin
            r_dac_data <= w_scaled;
            r_state    <= DAC_REQ;
          end else if (r_wait == 16'(FIR_TIMEOUT - 1)) begin
            r_timeout <= sat_inc16(r_timeout);
            r_state   <= IDLE;
          end else r_wait <= r_wait + 16'd1;
        DAC_REQ: if (dac_ack) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_sample_scheduler.sv
// tb_fir_sample_scheduler: randomized transaction-level checking of the sample scheduler.
module tb_fir_sample_scheduler;
  localparam int DIV   = 100;
  localparam int ACC_W = 21;
  localparam int TMO   = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [7:0] adc_data = 8'h00;
  logic adc_en, fir_in_valid, dac_req, busy;
  logic [7:0] fir_in_data, dac_data;
  logic signed [ACC_W-1:0] fir_out_data = '0;
  logic fir_out_valid = 1'b0;
  logic dac_ack = 1'b0;
  logic [15:0] overrun_cnt, timeout_cnt;
  int checks = 0;
  int errors = 0;
  int c, ph_start, idle_from;
  int t_adc, t_fiv, t_fov, t_req, t_ack, t_to, fw_lo, fw_hi;
  int exp_ovr, exp_to, fir_v;
  logic [7:0] exp_fin, exp_dac;
  logic prev_en;
  logic en_cfg = 1'b1;
  logic spur = 1'b0;
  logic rnd = 1'b0;
  int cfg_d = 5;
  int cfg_a = 3;
  logic [7:0] adc_q[$];
  int fir_q[$];

  fir_sample_scheduler #(.SAMPLE_DIV(DIV), .ACC_W(ACC_W), .SHIFT(10), .FIR_TIMEOUT(TMO)) dut (
    .clk_100MHz(clk),
    .rst_n(rst_n),
    .enable(enable),
`ifdef FIR_BYPASS_EN
    .bypass(1'b0),
`endif
    .adc_data(adc_data),
    .adc_en(adc_en),
    .fir_in_data(fir_in_data),
    .fir_in_valid(fir_in_valid),
    .fir_out_data(fir_out_data),
    .fir_out_valid(fir_out_valid),
    .dac_data(dac_data),
    .dac_req(dac_req),
    .dac_ack(dac_ack),
    .busy(busy),
    .overrun_cnt(overrun_cnt),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, c, got, exp);
    end
  endtask

  // floor(v / 2^10), clamped to a signed byte, shown as offset binary
  function automatic logic [7:0] ref_scale(input int v);
    int q;
    q = v / 1024;
    if (v < 0 && q * 1024 != v) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return 8'(q + 128);
  endfunction

  task automatic model_reset();
    c = 0; ph_start = 0; idle_from = 0; prev_en = 1'b0;
    t_adc = -100; t_fiv = -100; t_fov = -100; t_req = -100; t_ack = -100; t_to = -100;
    fw_lo = -100; fw_hi = -100; exp_ovr = 0; exp_to = 0;
  endtask

  task automatic plan();
    int d, a;
    logic [7:0] av;
    av = (adc_q.size() > 0) ? adc_q.pop_front() : 8'($urandom);
    adc_data = av;
    exp_fin = 8'(av + 8'd128);
    if ((fir_q.size() > 0)) fir_v = fir_q.pop_front();
    else fir_v = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 262143)) - 131072
                                             : int'($urandom_range(0, 2097151)) - 1048576;
    d = cfg_d;
    a = cfg_a;
    if (rnd) begin
      d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      a = ($urandom_range(0, 7) == 0) ? 120 : int'($urandom_range(0, 40));
    end
    t_adc = c + 1;
    t_fiv = c + 2;
    fw_lo = c + 3;
    if (d == 0) begin
      t_fov = -100; t_req = -100; t_ack = -100;
      t_to = c + 2 + TMO;
      fw_hi = t_to;
      idle_from = t_to + 1;
    end else begin
      t_fov = c + 2 + d;
      fw_hi = t_fov;
      t_req = t_fov + 1;
      t_ack = t_req + a;
      t_to = -100;
      idle_from = t_ack + 1;
      exp_dac = ref_scale(fir_v);
    end
  endtask

  task automatic check();
    logic req_exp;
    req_exp = (c >= t_req) && (c <= t_ack);
    chk("adc_en", 32'(adc_en), 32'(c == t_adc));
    chk("fir_in_valid", 32'(fir_in_valid), 32'(c == t_fiv));
    if (c == t_fiv) chk("fir_in_data", 32'(fir_in_data), 32'(exp_fin));
    chk("dac_req", 32'(dac_req), 32'(req_exp));
    if (req_exp) chk("dac_data", 32'(dac_data), 32'(exp_dac));
    chk("busy", 32'(busy), 32'((c >= t_adc) && (c < idle_from)));
    chk("overrun_cnt", 32'(overrun_cnt), 32'(exp_ovr));
    chk("timeout_cnt", 32'(timeout_cnt), 32'(exp_to));
  endtask

  task automatic drive();
    logic tick;
    enable = en_cfg;
    if (en_cfg && !prev_en) ph_start = c;
    prev_en = en_cfg;
    tick = en_cfg && ((c - ph_start) % DIV == DIV - 1);
    if (tick) begin
      if (c >= idle_from) plan();
      else exp_ovr++;
    end
    if (c == t_to) exp_to++;
    fir_out_valid = (c == t_fov) || (spur && $urandom_range(0, 15) == 0 && !(c >= fw_lo && c <= fw_hi));
    fir_out_data = (c == t_fov) ? ACC_W'(fir_v) : ACC_W'($urandom);
    dac_ack = (c == t_ack) || (spur && $urandom_range(0, 15) == 0 && !(c >= t_req && c <= t_ack));
    c++;
  endtask

  task automatic cycle();
    @(negedge clk);
    check();
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    fir_out_valid = 1'b0;
    dac_ack = 1'b0;
    repeat (n) @(negedge clk);
    model_reset();
    check();
    chk("rst_dac_data", 32'(dac_data), 32'd0);
    chk("rst_fir_in_data", 32'(fir_in_data), 32'd0);
    rst_n = 1'b1;
    drive();
  endtask

  initial begin
    int k;
    model_reset();
    apply_reset(3);
    adc_q.push_back(8'h00);
    adc_q.push_back(8'hFF);
    fir_q.push_back(64512);
    fir_q.push_back(-4096);
    fir_q.push_back(300000);
    fir_q.push_back(-300000);
    run(650);
    rnd = 1'b1; spur = 1'b1;
    run(3000);
    rnd = 1'b0; spur = 1'b0; cfg_d = 5; cfg_a = 250;
    run(700);
    cfg_d = 0;
    run(250);
    cfg_d = 5; cfg_a = 3; spur = 1'b1;
    en_cfg = 1'b0;
    run(150);
    en_cfg = 1'b1;
    run(300);
    spur = 1'b0; cfg_a = 92;
    run(400);
    cfg_a = 50;
    k = 0;
    while (!(c >= t_req && c <= t_ack) && k < 400) begin
      cycle();
      k++;
    end
    @(negedge clk);
    check();
    chk("req_before_reset", 32'(dac_req), 32'd1);
    apply_reset(1);
    cfg_a = 3;
    run(350);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle %0d got no finish expected finish", c);
    $fatal(1, "watchdog");
  end
endmodule
